// File: rtl/tcp_tx_noc_out_seq.sv
`default_nettype none
// ============================================================================
// Module      : tcp_tx_noc_out_seq
// Description : Multi-source NoC packet sequencer for the TCP TX tile egress
//               port. Round-robin arbitration among NUM_SRC engines; each
//               grant emits one packet on noc0: header flit, META_FLITS
//               metadata flits latched with the header, then exactly the
//               announced number of payload flits.
// Ports       : clk, rst                 clock / synchronous active-high reset
//               i_src_hdr_val/o_src_hdr_rdy, i_src_hdr_flit, i_src_hdr_meta,
//               i_src_hdr_data_flits     per-source header channel
//               i_src_data_val/o_src_data_rdy, i_src_data
//                                        per-source payload channel
//               o_noc_out_val/i_noc_out_rdy, o_noc_out_data, o_noc_out_last,
//               o_noc_out_src            noc0 egress channel
// Revision    : 1.0 - initial release
// ============================================================================
module tcp_tx_noc_out_seq #(
    parameter  int NUM_SRC    = 4,
    parameter  int NOC_DATA_W = 512,
    parameter  int META_FLITS = 1,
    parameter  int LEN_W      = 8,
    localparam int SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int META_W     = (META_FLITS > 0) ? NUM_SRC * META_FLITS * NOC_DATA_W : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            i_src_hdr_val,
    output logic [NUM_SRC-1:0]            o_src_hdr_rdy,
    input  logic [NUM_SRC*NOC_DATA_W-1:0] i_src_hdr_flit,
    input  logic [META_W-1:0]             i_src_hdr_meta,
    input  logic [NUM_SRC*LEN_W-1:0]      i_src_hdr_data_flits,
    input  logic [NUM_SRC-1:0]            i_src_data_val,
    output logic [NUM_SRC-1:0]            o_src_data_rdy,
    input  logic [NUM_SRC*NOC_DATA_W-1:0] i_src_data,
    output logic                          o_noc_out_val,
    input  logic                          i_noc_out_rdy,
    output logic [NOC_DATA_W-1:0]         o_noc_out_data,
    output logic                          o_noc_out_last,
    output logic [SRC_W-1:0]              o_noc_out_src
);

    localparam int MI_W = (META_FLITS > 1) ? $clog2(META_FLITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_META = 2'd1,
        S_DATA = 2'd2
    } t_state;

    t_state              r_state;
    logic [SRC_W-1:0]    r_rr_ptr;
    logic                r_lock;
    logic [SRC_W-1:0]    r_lock_idx;
    logic [SRC_W-1:0]    r_grant;
    logic [LEN_W-1:0]    r_cnt;
    logic [MI_W-1:0]     r_meta_idx;
    logic                r_init;       // high for the first cycle after reset

    logic [SRC_W-1:0]      w_scan;
    logic                  w_found;
    logic [SRC_W-1:0]      w_cand;
    logic [SRC_W-1:0]      w_rr_next;
    logic [LEN_W-1:0]      w_hdr_cnt;
    logic [NOC_DATA_W-1:0] w_meta_flit;
    logic                  w_en;
    logic                  w_xfer;
    logic                  w_hdr_acc;
    logic                  w_meta_last;
    logic                  w_val;
    logic [NOC_DATA_W-1:0] w_data;
    logic                  w_last;
    logic [SRC_W-1:0]      w_src;

    // Outputs are held quiet while in reset and for one cycle afterwards.
    assign w_en = !rst && !r_init;

    // Round-robin scan starting at r_rr_ptr.
    always_comb begin
        w_found = 1'b0;
        w_scan  = r_rr_ptr;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!w_found && i_src_hdr_val[(int'(r_rr_ptr) + k) % NUM_SRC]) begin
                w_found = 1'b1;
                w_scan  = SRC_W'((int'(r_rr_ptr) + k) % NUM_SRC);
            end
        end
    end

    // A stalled header keeps its source so the offer cannot switch mid-stall.
    assign w_cand      = r_lock ? r_lock_idx : w_scan;
    assign w_rr_next   = SRC_W'((int'(w_cand) + 1) % NUM_SRC);
    assign w_hdr_cnt   = i_src_hdr_data_flits[int'(w_cand)*LEN_W +: LEN_W];
    assign w_meta_last = (r_meta_idx == MI_W'(META_FLITS - 1));

    always_comb begin
        o_src_hdr_rdy  = '0;
        o_src_data_rdy = '0;
        w_val          = 1'b0;
        w_data         = '0;
        w_last         = 1'b0;
        w_src          = r_grant;
        case (r_state)
            S_IDLE: begin
                w_src                 = w_cand;
                w_val                 = i_src_hdr_val[w_cand];
                w_data                = i_src_hdr_flit[int'(w_cand)*NOC_DATA_W +: NOC_DATA_W];
                w_last                = w_val && (META_FLITS == 0) && (w_hdr_cnt == '0);
                o_src_hdr_rdy[w_cand] = i_noc_out_rdy && w_en;
            end
            S_META: begin
                w_val  = 1'b1;
                w_data = w_meta_flit;
                w_last = w_meta_last && (r_cnt == '0);
            end
            S_DATA: begin
                w_val                   = i_src_data_val[r_grant];
                w_data                  = i_src_data[int'(r_grant)*NOC_DATA_W +: NOC_DATA_W];
                w_last                  = w_val && (r_cnt == LEN_W'(1));
                o_src_data_rdy[r_grant] = i_noc_out_rdy && w_en;
            end
            default: ;
        endcase
    end

    assign o_noc_out_val  = w_val && w_en;
    assign o_noc_out_data = w_en ? w_data : '0;
    assign o_noc_out_last = w_last && w_en;
    assign o_noc_out_src  = w_en ? w_src : '0;

    assign w_xfer    = o_noc_out_val && i_noc_out_rdy;
    assign w_hdr_acc = (r_state == S_IDLE) && w_xfer;

    // Metadata is captured alongside the header so the source may move on.
    generate
        if (META_FLITS > 0) begin : g_meta
            logic [NOC_DATA_W-1:0] r_meta [META_FLITS];

            always_ff @(posedge clk) begin
                if (w_hdr_acc) begin
                    for (int k = 0; k < META_FLITS; k++) begin
                        r_meta[k] <= i_src_hdr_meta[(int'(w_cand)*META_FLITS + k)*NOC_DATA_W +: NOC_DATA_W];
                    end
                end
            end

            assign w_meta_flit = r_meta[r_meta_idx];
        end else begin : g_no_meta
            assign w_meta_flit = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
            r_grant    <= '0;
            r_cnt      <= '0;
            r_meta_idx <= '0;
            r_init     <= 1'b1;
        end else begin
            r_init <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_grant    <= w_cand;
                        r_lock     <= 1'b0;
                        r_rr_ptr   <= w_rr_next;
                        r_cnt      <= w_hdr_cnt;
                        r_meta_idx <= '0;
                        if (META_FLITS > 0) begin
                            r_state <= S_META;
                        end else if (w_hdr_cnt != '0) begin
                            r_state <= S_DATA;
                        end
                    end else if (o_noc_out_val) begin
                        r_lock     <= 1'b1;
                        r_lock_idx <= w_cand;
                    end
                end
                S_META: begin
                    if (w_xfer) begin
                        r_meta_idx <= r_meta_idx + MI_W'(1);
                        if (w_meta_last) begin
                            r_state <= (r_cnt != '0) ? S_DATA : S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_cnt <= r_cnt - LEN_W'(1);
                        if (r_cnt == LEN_W'(1)) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tcp_tx_noc_out_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_tcp_tx_noc_out_seq
// Description : Directed self-checking bench for tcp_tx_noc_out_seq. Three
//               instances cover 4 sources / 2 meta flits (A), 4 sources / no
//               meta (B) and a single source / 1 meta flit (C).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tcp_tx_noc_out_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // Instance A: NUM_SRC=4, META_FLITS=2, 32-bit flits
    logic [3:0]   a_hval, a_hrdy, a_dval, a_drdy;
    logic [127:0] a_hflit, a_data;
    logic [255:0] a_meta;
    logic [31:0]  a_cnt;
    logic         a_val, a_rdy, a_last;
    logic [31:0]  a_dout;
    logic [1:0]   a_src;

    // Instance B: NUM_SRC=4, META_FLITS=0
    logic [3:0]   b_hval, b_hrdy, b_dval, b_drdy;
    logic [127:0] b_hflit, b_data;
    logic         b_meta;
    logic [31:0]  b_cnt;
    logic         b_val, b_rdy, b_last;
    logic [31:0]  b_dout;
    logic [1:0]   b_src;

    // Instance C: NUM_SRC=1, META_FLITS=1
    logic         c_hval, c_hrdy, c_dval, c_drdy;
    logic [31:0]  c_hflit, c_data, c_meta;
    logic [7:0]   c_cnt;
    logic         c_val, c_rdy, c_last;
    logic [31:0]  c_dout;
    logic [0:0]   c_src;

    tcp_tx_noc_out_seq #(.NUM_SRC(4), .NOC_DATA_W(32), .META_FLITS(2), .LEN_W(8)) u_dut_a (
        .clk(clk), .rst(rst),
        .i_src_hdr_val(a_hval), .o_src_hdr_rdy(a_hrdy), .i_src_hdr_flit(a_hflit),
        .i_src_hdr_meta(a_meta), .i_src_hdr_data_flits(a_cnt),
        .i_src_data_val(a_dval), .o_src_data_rdy(a_drdy), .i_src_data(a_data),
        .o_noc_out_val(a_val), .i_noc_out_rdy(a_rdy), .o_noc_out_data(a_dout),
        .o_noc_out_last(a_last), .o_noc_out_src(a_src)
    );

    tcp_tx_noc_out_seq #(.NUM_SRC(4), .NOC_DATA_W(32), .META_FLITS(0), .LEN_W(8)) u_dut_b (
        .clk(clk), .rst(rst),
        .i_src_hdr_val(b_hval), .o_src_hdr_rdy(b_hrdy), .i_src_hdr_flit(b_hflit),
        .i_src_hdr_meta(b_meta), .i_src_hdr_data_flits(b_cnt),
        .i_src_data_val(b_dval), .o_src_data_rdy(b_drdy), .i_src_data(b_data),
        .o_noc_out_val(b_val), .i_noc_out_rdy(b_rdy), .o_noc_out_data(b_dout),
        .o_noc_out_last(b_last), .o_noc_out_src(b_src)
    );

    tcp_tx_noc_out_seq #(.NUM_SRC(1), .NOC_DATA_W(32), .META_FLITS(1), .LEN_W(8)) u_dut_c (
        .clk(clk), .rst(rst),
        .i_src_hdr_val(c_hval), .o_src_hdr_rdy(c_hrdy), .i_src_hdr_flit(c_hflit),
        .i_src_hdr_meta(c_meta), .i_src_hdr_data_flits(c_cnt),
        .i_src_data_val(c_dval), .o_src_data_rdy(c_drdy), .i_src_data(c_data),
        .o_noc_out_val(c_val), .i_noc_out_rdy(c_rdy), .o_noc_out_data(c_dout),
        .o_noc_out_last(c_last), .o_noc_out_src(c_src)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        a_hval  = '0; a_dval = '0; a_rdy = 1'b1;
        a_hflit = {32'hAA00_0003, 32'hAA00_0002, 32'hAA00_0001, 32'hAA00_0000};
        a_meta  = {32'hCC00_0031, 32'hCC00_0030, 32'hCC00_0021, 32'hCC00_0020,
                   32'hCC00_0011, 32'hCC00_0010, 32'hCC00_0001, 32'hCC00_0000};
        a_cnt   = 32'h0000_0003;          // src0: 3 payload flits, others 0
        a_data  = '0;
        b_hval  = '0; b_dval = '0; b_rdy = 1'b1; b_meta = 1'b0; b_cnt = '0; b_data = '0;
        b_hflit = {32'hBB00_0003, 32'hBB00_0002, 32'hBB00_0001, 32'hBB00_0000};
        c_hval  = 1'b1; c_hflit = 32'h4848_0001; c_meta = 32'h4D4D_0001; c_cnt = 8'd3;
        c_dval  = 1'b0; c_data = '0; c_rdy = 1'b1;

        // Reset: outputs quiet during reset and for the cycle after it
        tick(); tick();
        settle();
        chk("rst_c_val",  64'(c_val),  64'd0);
        chk("rst_c_hrdy", 64'(c_hrdy), 64'd0);
        tick(); rst = 1'b0;
        settle();
        chk("postrst_c_val",  64'(c_val),  64'd0);
        chk("postrst_c_data", 64'(c_dout), 64'd0);

        // Test 1: single source, H, M, D0..D2
        tick(); settle();
        chk("t1_h_val",  64'(c_val),  64'd1);
        chk("t1_h_data", 64'(c_dout), 64'h4848_0001);
        chk("t1_h_last", 64'(c_last), 64'd0);
        chk("t1_h_rdy",  64'(c_hrdy), 64'd1);
        tick(); c_hval = 1'b0; c_dval = 1'b1; c_data = 32'h0000_00D0;
        settle();
        chk("t1_m_data", 64'(c_dout), 64'h4D4D_0001);
        chk("t1_m_last", 64'(c_last), 64'd0);
        chk("t1_m_drdy", 64'(c_drdy), 64'd0);
        tick(); settle();
        chk("t1_d0_data", 64'(c_dout), 64'h00D0);
        chk("t1_d0_last", 64'(c_last), 64'd0);
        chk("t1_d0_drdy", 64'(c_drdy), 64'd1);
        tick(); c_data = 32'h0000_00D1;
        settle();
        chk("t1_d1_data", 64'(c_dout), 64'h00D1);
        chk("t1_d1_last", 64'(c_last), 64'd0);
        tick(); c_data = 32'h0000_00D2;
        settle();
        chk("t1_d2_data", 64'(c_dout), 64'h00D2);
        chk("t1_d2_last", 64'(c_last), 64'd1);
        tick(); c_dval = 1'b0;
        settle();
        chk("t1_idle_val", 64'(c_val), 64'd0);

        // Test 2: four sources requesting continuously, zero-length packets
        tick(); b_hval = 4'hF;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            settle();
            chk("t2_src",  64'(b_src),  64'(i % 4));
            chk("t2_data", 64'(b_dout), 64'h0000_0000_BB00_0000 + 64'(i % 4));
            chk("t2_last", 64'(b_last), 64'd1);
        end
        tick(); b_hval = 4'h0;
        settle();
        chk("t2_idle_val", 64'(b_val), 64'd0);

        // Test 3: stalled header from src 2 stays locked while src 0 raises val
        tick(); a_hval = 4'b0100; a_rdy = 1'b0;
        settle();
        chk("t3_s1_val",  64'(a_val),  64'd1);
        chk("t3_s1_src",  64'(a_src),  64'd2);
        chk("t3_s1_data", 64'(a_dout), 64'hAA00_0002);
        chk("t3_s1_hrdy", 64'(a_hrdy), 64'd0);
        tick(); a_hval = 4'b0101;
        settle();
        chk("t3_s2_src",  64'(a_src),  64'd2);
        chk("t3_s2_data", 64'(a_dout), 64'hAA00_0002);
        tick(); settle();
        chk("t3_s3_src",  64'(a_src),  64'd2);
        tick(); a_rdy = 1'b1;
        settle();
        chk("t3_acc_src",  64'(a_src),  64'd2);
        chk("t3_acc_hrdy", 64'(a_hrdy), 64'b0100);
        tick(); a_hval = 4'b0001;
        settle();
        chk("t3_m0_data", 64'(a_dout), 64'hCC00_0020);
        chk("t3_m0_src",  64'(a_src),  64'd2);
        chk("t3_m0_hrdy", 64'(a_hrdy), 64'd0);
        tick(); settle();
        chk("t3_m1_data", 64'(a_dout), 64'hCC00_0021);
        chk("t3_m1_last", 64'(a_last), 64'd1);
        tick(); settle();
        chk("t3_next_src",  64'(a_src),  64'd0);
        chk("t3_next_data", 64'(a_dout), 64'hAA00_0000);
        chk("t3_next_hrdy", 64'(a_hrdy), 64'b0001);

        // Test 4: src 0 payload (3 flits) with val and rdy toggling
        tick(); a_hval = 4'b0000;
        settle();
        chk("t4_m0_data", 64'(a_dout), 64'hCC00_0000);
        tick(); settle();
        chk("t4_m1_data", 64'(a_dout), 64'hCC00_0001);
        chk("t4_m1_last", 64'(a_last), 64'd0);
        tick(); a_dval = 4'b0001; a_data = {96'd0, 32'hD00D_0000};
        settle();
        chk("t4_d0_data", 64'(a_dout), 64'hD00D_0000);
        chk("t4_d0_drdy", 64'(a_drdy), 64'b0001);
        chk("t4_d0_last", 64'(a_last), 64'd0);
        tick(); a_dval = 4'b0000;
        settle();
        chk("t4_gap_val",  64'(a_val),  64'd0);
        chk("t4_gap_last", 64'(a_last), 64'd0);
        tick(); a_dval = 4'b0001; a_rdy = 1'b0; a_data = {96'd0, 32'hD00D_0001};
        settle();
        chk("t4_stall_val",  64'(a_val),  64'd1);
        chk("t4_stall_drdy", 64'(a_drdy), 64'd0);
        chk("t4_stall_last", 64'(a_last), 64'd0);
        tick(); a_rdy = 1'b1;
        settle();
        chk("t4_d1_data", 64'(a_dout), 64'hD00D_0001);
        chk("t4_d1_last", 64'(a_last), 64'd0);
        tick(); a_data = {96'd0, 32'hD00D_0002};
        settle();
        chk("t4_d2_data", 64'(a_dout), 64'hD00D_0002);
        chk("t4_d2_last", 64'(a_last), 64'd1);
        tick(); settle();
        chk("t4_done_val",  64'(a_val),  64'd0);
        chk("t4_done_drdy", 64'(a_drdy), 64'd0);

        // Test 5: src 1, two meta flits, zero payload
        tick(); a_dval = 4'b0000; a_hval = 4'b0010;
        settle();
        chk("t5_h_src",  64'(a_src),  64'd1);
        chk("t5_h_data", 64'(a_dout), 64'hAA00_0001);
        chk("t5_h_last", 64'(a_last), 64'd0);
        tick(); a_hval = 4'b0000;
        settle();
        chk("t5_m0_data", 64'(a_dout), 64'hCC00_0010);
        chk("t5_m0_last", 64'(a_last), 64'd0);
        tick(); settle();
        chk("t5_m1_data", 64'(a_dout), 64'hCC00_0011);
        chk("t5_m1_last", 64'(a_last), 64'd1);
        tick(); settle();
        chk("t5_idle_val", 64'(a_val), 64'd0);

        // Test 6: reset in the middle of a src 2 payload (7 flits)
        tick(); a_cnt = 32'h0007_0000; a_hval = 4'b0100;
        settle();
        chk("t6_h_src", 64'(a_src), 64'd2);
        tick(); a_hval = 4'b0000;
        tick();
        tick(); a_dval = 4'b0100; a_data = {32'd0, 32'h0000_00E0, 64'd0};
        settle();
        chk("t6_d0_data", 64'(a_dout), 64'h00E0);
        chk("t6_d0_drdy", 64'(a_drdy), 64'b0100);
        tick();
        tick(); rst = 1'b1;
        settle();
        chk("t6_rst_val",  64'(a_val),  64'd0);
        chk("t6_rst_drdy", 64'(a_drdy), 64'd0);
        tick(); rst = 1'b0; a_hval = 4'b0001; a_cnt = 32'h0000_0000;
        settle();
        chk("t6_post_val", 64'(a_val), 64'd0);
        tick(); settle();
        chk("t6_new_val",  64'(a_val),  64'd1);
        chk("t6_new_src",  64'(a_src),  64'd0);
        chk("t6_new_data", 64'(a_dout), 64'hAA00_0000);
        chk("t6_new_drdy", 64'(a_drdy), 64'd0);
        tick(); a_hval = 4'b0000;
        settle();
        chk("t6_new_m0", 64'(a_dout), 64'hCC00_0000);
        chk("t6_new_m0_src", 64'(a_src), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
